// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side sram-like to AXI4 read-only bridge.
// Single-beat reads, in-order responses under one ID.
module inst_axi_rd_bridge #(
    parameter logic [3:0] ARID    = 4'd0,
    parameter int         MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUT);

    logic       ar_pending;
    logic [1:0] out_cnt;
    logic       accept;
    logic       r_done;
    logic       unused_ok;

    assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb,
                         inst_sram_wdata, rid, rresp};

    // addrok must stay independent of req: if_stage loops it back into req
    assign inst_sram_addrok = !reset && !ar_pending && (out_cnt < MAX_CNT);
    assign accept = inst_sram_req && inst_sram_addrok;
    assign r_done = rvalid && rready && rlast && (out_cnt != 2'd0);

    assign inst_sram_dataok = !reset && rvalid && (out_cnt != 2'd0);
    assign inst_sram_rdata  = rdata;

    assign arid    = ARID;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = ar_pending;
    assign rready  = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_pending <= 1'b0;
            araddr     <= 32'd0;
            arsize     <= 3'd2;
        end else if (accept) begin
            ar_pending <= 1'b1;
            araddr     <= inst_sram_addr;
            arsize     <= {1'b0, inst_sram_size};
        end else if (arvalid && arready) begin
            ar_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt <= 2'd0;
        end else begin
            unique case ({accept, r_done})
                2'b10:   out_cnt <= out_cnt + 2'd1;
                2'b01:   out_cnt <= out_cnt - 2'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge with a dataok scoreboard.
module tb_inst_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addrok;
    logic        inst_sram_dataok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUT(2)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addrok(inst_sram_addrok), .inst_sram_dataok(inst_sram_dataok),
        .inst_sram_rdata(inst_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every dataok pulse must match the oldest request.
    always @(negedge clk) begin
        if (inst_sram_dataok === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL dataok_unexpected: got %h want none",
                         inst_sram_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (inst_sram_rdata !== e) begin
                    bad++;
                    $display("FAIL rdata_order: got %h want %h",
                             inst_sram_rdata, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_req = 1'b1;
        inst_sram_wr = 1'b0;
        inst_sram_size = 2'd2;
        inst_sram_addr = 32'h1fc00000;
        inst_sram_wstrb = 4'h0;
        inst_sram_wdata = 32'h0;
        arready = 1'b0;
        rid = 4'd0;
        rdata = 32'hffffffff;
        rresp = 2'd0;
        rlast = 1'b1;
        rvalid = 1'b1;

        // reset with rvalid and req asserted
        step();
        mid();
        chk("rst_addrok", 32'(inst_sram_addrok), 32'd0);
        chk("rst_dataok", 32'(inst_sram_dataok), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        step();
        reset = 1'b0;
        rvalid = 1'b0;
        inst_sram_req = 1'b0;
        mid();
        chk("post_rst_addrok", 32'(inst_sram_addrok), 32'd1);
        chk("post_rst_arsize", 32'(arsize), 32'd2);

        // single fetch, best-case latency
        step();
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1fc00000;
        arready = 1'b1;
        exp_q.push_back(32'h3c080001);
        mid();
        chk("t2_addrok", 32'(inst_sram_addrok), 32'd1);
        step();
        inst_sram_req = 1'b0;
        mid();
        chk("t2_arvalid", 32'(arvalid), 32'd1);
        chk("t2_araddr", araddr, 32'h1fc00000);
        chk("t2_arsize", 32'(arsize), 32'd2);
        chk("t2_arlen", 32'(arlen), 32'd0);
        chk("t2_arburst", 32'(arburst), 32'd1);
        chk("t2_arid", 32'(arid), 32'd0);
        step();
        rvalid = 1'b1;
        rdata = 32'h3c080001;
        mid();
        chk("t2_dataok", 32'(inst_sram_dataok), 32'd1);
        chk("t2_arvalid_clr", 32'(arvalid), 32'd0);
        step();
        rvalid = 1'b0;
        mid();
        chk("t2_dataok_once", 32'(inst_sram_dataok), 32'd0);

        // AR stall: arready low for 3 cycles
        step();
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1fc00010;
        arready = 1'b0;
        exp_q.push_back(32'h24020003);
        mid();
        chk("t3_addrok", 32'(inst_sram_addrok), 32'd1);
        step();
        inst_sram_req = 1'b0;
        inst_sram_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t3_arvalid_hold", 32'(arvalid), 32'd1);
            chk("t3_araddr_hold", araddr, 32'h1fc00010);
            chk("t3_addrok_low", 32'(inst_sram_addrok), 32'd0);
            step();
        end
        arready = 1'b1;
        mid();
        chk("t3_arvalid_4th", 32'(arvalid), 32'd1);
        step();
        mid();
        chk("t3_addrok_reopen", 32'(inst_sram_addrok), 32'd1);
        step();
        rvalid = 1'b1;
        rdata = 32'h24020003;
        step();
        rvalid = 1'b0;

        // two outstanding, R withheld, req held high
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1fc00000;
        exp_q.push_back(32'h11110000);
        mid();
        chk("t4_addrok_a0", 32'(inst_sram_addrok), 32'd1);
        step();
        inst_sram_addr = 32'h1fc00004;
        mid();
        chk("t4_ar0_addr", araddr, 32'h1fc00000);
        chk("t4_addrok_pend", 32'(inst_sram_addrok), 32'd0);
        step();
        exp_q.push_back(32'h11110004);
        mid();
        chk("t4_addrok_a1", 32'(inst_sram_addrok), 32'd1);
        step();
        mid();
        chk("t4_ar1_addr", araddr, 32'h1fc00004);
        chk("t4_ar1_valid", 32'(arvalid), 32'd1);
        step();
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("t4_full_addrok", 32'(inst_sram_addrok), 32'd0);
            chk("t4_full_arvalid", 32'(arvalid), 32'd0);
            step();
        end
        rvalid = 1'b1;
        rdata = 32'h11110000;
        mid();
        chk("t4_full_addrok_r", 32'(inst_sram_addrok), 32'd0);
        step();
        rvalid = 1'b0;
        inst_sram_req = 1'b0;
        mid();
        chk("t4_reopen", 32'(inst_sram_addrok), 32'd1);

        // accept and R beat in the same cycle with one outstanding
        step();
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1fc00008;
        rvalid = 1'b1;
        rdata = 32'h11110004;
        exp_q.push_back(32'h11110008);
        mid();
        chk("t5_addrok", 32'(inst_sram_addrok), 32'd1);
        chk("t5_dataok", 32'(inst_sram_dataok), 32'd1);
        step();
        inst_sram_req = 1'b0;
        rvalid = 1'b0;
        mid();
        chk("t5_arvalid", 32'(arvalid), 32'd1);
        chk("t5_araddr", araddr, 32'h1fc00008);
        step();
        mid();
        chk("t5_cnt1_addrok", 32'(inst_sram_addrok), 32'd1);
        step();
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1fc0000c;
        exp_q.push_back(32'h1111000c);
        step();
        inst_sram_req = 1'b0;
        step();
        mid();
        chk("t5_cnt2_addrok", 32'(inst_sram_addrok), 32'd0);
        step();
        rvalid = 1'b1;
        rdata = 32'h11110008;
        step();
        rdata = 32'h1111000c;
        step();
        rvalid = 1'b0;

        // spurious beat with nothing outstanding
        rvalid = 1'b1;
        rdata = 32'hdeadbeef;
        mid();
        chk("t6_dataok", 32'(inst_sram_dataok), 32'd0);
        chk("t6_rready", 32'(rready), 32'd1);
        chk("t6_addrok", 32'(inst_sram_addrok), 32'd1);
        step();
        rvalid = 1'b0;
        inst_sram_req = 1'b1;
        inst_sram_addr = 32'h1fc00020;
        inst_sram_size = 2'd1;
        exp_q.push_back(32'h22220020);
        step();
        inst_sram_req = 1'b0;
        mid();
        chk("t6_arsize", 32'(arsize), 32'd1);
        step();
        mid();
        chk("t6_cnt1_addrok", 32'(inst_sram_addrok), 32'd1);
        step();
        rvalid = 1'b1;
        rdata = 32'h22220020;
        step();
        rvalid = 1'b0;
        step();
        step();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Converts the instruction-side sram-like interface driven by if_stage into an AXI4 read-only master.
- Sits directly upstream of if_stage: it produces inst_sram_addrok, inst_sram_dataok and inst_sram_rdata, and consumes if_stage's request.
- Tracks up to MAX_OUT outstanding single-beat reads; the AXI slave returns responses in order under one ID.

Parameters:
- ARID, 4'd0: fixed AXI ID driven on arid.
- MAX_OUT, 2: maximum accepted-but-unanswered reads (1..3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_sram_req  in  1  request valid
- inst_sram_wr  in  1  write flag; ignored, every request is a read
- inst_sram_size  in  2  log2 of the byte count (2 = word)
- inst_sram_addr  in  32  physical fetch address
- inst_sram_wstrb  in  4  ignored
- inst_sram_wdata  in  32  ignored
- inst_sram_addrok  out  1  bridge can accept a request this cycle
- inst_sram_dataok  out  1  one-cycle pulse, rdata valid
- inst_sram_rdata  out  32  returned instruction
- arid  out  4  equals ARID
- araddr  out  32  read address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, captured size}
- arburst  out  2  constant 2'b01 (INCR)
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  ignored
- rdata  in  32  read data
- rresp  in  2  ignored
- rlast  in  1  last beat; always 1 because arlen is 0
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: one clock, synchronous, active-high.
  - On reset: arvalid=0, ar_pending=0, out_cnt=0, araddr=0, arsize=3'd2.
  - While reset is high, inst_sram_addrok=0 and inst_sram_dataok=0.
- addrok:
  - inst_sram_addrok = !reset && !ar_pending && (out_cnt < MAX_OUT).
  - It must not depend on inst_sram_req; if_stage feeds addrok back combinationally into req.
- Accept:
  - A request is accepted when inst_sram_req && inst_sram_addrok at cycle T.
  - At T+1: araddr<=inst_sram_addr, arsize<={1'b0,inst_sram_size}, ar_pending<=1, arvalid=1.
- AR channel:
  - arvalid = ar_pending; araddr and arsize are held stable while arvalid=1.
  - When arvalid && arready, ar_pending is cleared on the next edge, which reopens addrok.
  - The best-case accept rate is therefore one request per 2 cycles when arready is held high.
- Outstanding counter out_cnt (2 bits):
  - +1 on accept.
  - -1 on a valid R handshake (rvalid && rready && rlast && out_cnt!=0).
  - Accept and R handshake in the same cycle: out_cnt is unchanged.
  - out_cnt never exceeds MAX_OUT and never wraps below 0.
- R channel:
  - rready is always 1; if_stage buffers the data itself.
  - inst_sram_dataok = rvalid && (out_cnt!=0), combinational, same cycle as the beat.
  - inst_sram_rdata = rdata, passed through combinationally.
  - Responses map to accepted requests in acceptance order.
- Spurious rvalid while out_cnt==0: the beat is consumed (rready=1), dataok stays 0, and the counter is unchanged.
- Pipeline cancel: the bridge has no cancel input. Every accepted request completes on AXI and pulses dataok; if_stage discards stale data itself.
- No write channels: AW/W/B are not present, and the top level ties them off.
- rresp errors are not reported: data is passed through and dataok is pulsed as usual.
- Latency: best case request at T, arvalid at T+1, rvalid at T+2, dataok at T+2.

Test Plan:
- Reset with rvalid=1 and req=1 -> addrok=0, dataok=0, arvalid=0; on the first cycle after release, addrok=1 and out_cnt=0.
- req=1, addr=32'h1fc00000, size=2, arready=1, slave replies rdata=32'h3c080001 one cycle after the AR handshake -> araddr=32'h1fc00000, arsize=3'd2, arlen=0, arburst=1, arid=0. dataok pulses exactly once with rdata=32'h3c080001, and out_cnt returns to 0.
- arready held 0 for 3 cycles after an accept -> arvalid and araddr held stable for all 3 cycles with addrok=0. The AR handshake completes on the 4th cycle, and addrok=1 on the following cycle.
- MAX_OUT=2, arready=1, R withheld, req held 1 with addrs 0x1fc00000 then 0x1fc00004 -> two AR handshakes occur, then addrok stays 0 with out_cnt=2. The first R beat reopens addrok (out_cnt=1). Data arrive in address order with two dataok pulses.
- With out_cnt=1, an accept and an R beat land in the same cycle -> out_cnt stays 1, dataok=1 in that cycle, and arvalid=1 next cycle.
- rvalid=1 with out_cnt=0 (spurious) -> dataok=0, rready=1, out_cnt stays 0, addrok unaffected.
